// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port crossbar arbiter: round-robin grant among masters targeting
// this slave, ownership held until write ack / read resp, with optional
// timeout abort and protocol-error detection on early request drop.
module xbar_slave_arbiter #(
  parameter int N        = 4,
  parameter int SW       = $clog2(N),
  parameter int SLAVE_ID = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    m_req,
  input  logic [N*SW-1:0] m_tgt,
  input  logic [N-1:0]    m_cmd,
  input  logic            s_ack,
  input  logic            s_resp,
  output logic            s_req,
  output logic            gnt_valid,
  output logic [SW-1:0]   gnt_idx,
  output logic [N-1:0]    m_ack,
  output logic [N-1:0]    m_resp,
  output logic            timeout,
  output logic            proto_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state_q, state_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [SW-1:0] gnt_idx_q, gnt_idx_d;
  logic [SW-1:0] last_q, last_d;
  logic          cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          proto_err_q, proto_err_d;

  logic [N-1:0]  eligible;
  logic [SW-1:0] pick;
  logic [SW-1:0] cand;
  logic          found;
  logic [CW-1:0] cnt_inc;
  logic          tmo_hit;

  // Eligibility mask and round-robin pick starting just after the last grant
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible[i] = m_req[i] && (m_tgt[i*SW +: SW] == SW'(SLAVE_ID));
    end
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = last_q + SW'(k);
      if (!found && eligible[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state logic; completion beats protocol error beats timeout
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    tmo_hit     = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = REQ;
          gnt_idx_d   = pick;
          last_d      = pick;
          cmd_d       = m_cmd[pick];
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      REQ: begin
        if (s_ack) begin
          if (cmd_q) begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end else if (!m_req[gnt_idx_q]) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end else if (tmo_hit) begin
          timeout_d   = 1'b1;
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (s_resp) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end else if (tmo_hit) begin
          timeout_d   = 1'b1;
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      last_q      <= SW'(N - 1);
      cmd_q       <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Slave request and ack/resp steering back to the owning master
  always_comb begin
    s_req  = (state_q == REQ) && m_req[gnt_idx_q];
    m_ack  = '0;
    m_resp = '0;
    if (state_q == REQ)  m_ack[gnt_idx_q]  = s_ack;
    if (state_q == RESP) m_resp[gnt_idx_q] = s_resp;
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter with N=4, SLAVE_ID=2, TIMEOUT=8.
module tb_xbar_slave_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] m_req;
  logic [7:0] m_tgt;
  logic [3:0] m_cmd;
  logic       s_ack;
  logic       s_resp;
  logic       s_req;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] m_ack;
  logic [3:0] m_resp;
  logic       timeout;
  logic       proto_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  xbar_slave_arbiter #(
    .N(4),
    .SLAVE_ID(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_req(m_req),
    .m_tgt(m_tgt),
    .m_cmd(m_cmd),
    .s_ack(s_ack),
    .s_resp(s_resp),
    .s_req(s_req),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx),
    .m_ack(m_ack),
    .m_resp(m_resp),
    .timeout(timeout),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tg(input logic [1:0] t0, input logic [1:0] t1,
                                    input logic [1:0] t2, input logic [1:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  logic [1:0] rr_order [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

  initial begin
    rst_n = 1'b0; m_req = '0; m_tgt = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0;
    tick(); tick();
    check("rst_gnt_valid", 32'(gnt_valid), 0);
    check("rst_gnt_idx", 32'(gnt_idx), 0);
    check("rst_s_req", 32'(s_req), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    rst_n = 1'b1;

    // Single write from master 1, slave acks two cycles after s_req
    m_req = 4'b0010; m_cmd = 4'b0010; m_tgt = tg(0, 2, 0, 0);
    tick();
    check("wr_gnt_idx", 32'(gnt_idx), 1);
    check("wr_gnt_valid", 32'(gnt_valid), 1);
    check("wr_s_req", 32'(s_req), 1);
    check("wr_m_ack_pre", 32'(m_ack), 0);
    tick();
    check("wr_m_ack_wait", 32'(m_ack), 0);
    tick();
    s_ack = 1'b1; #1;
    check("wr_m_ack", 32'(m_ack), 4'b0010);
    check("wr_m_resp", 32'(m_resp), 0);
    tick();
    s_ack = 1'b0; m_req = '0; #1;
    check("wr_done_valid", 32'(gnt_valid), 0);
    check("wr_done_ack", 32'(m_ack), 0);
    check("wr_done_idx_hold", 32'(gnt_idx), 1);
    check("wr_done_resp", 32'(m_resp), 0);

    // Round robin among masters 0,1,3 with immediate acks
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_req = 4'b1011; m_cmd = 4'b1111; m_tgt = tg(2, 2, 0, 2); s_ack = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("rr_gnt_idx", 32'(gnt_idx), 32'(rr_order[g]));
      check("rr_m_ack", 32'(m_ack), 32'(4'b0001 << rr_order[g]));
      tick();
      check("rr_idle_gap", 32'(gnt_valid), 0);
      check("rr_idle_ack", 32'(m_ack), 0);
    end
    m_req = '0; s_ack = 1'b0;
    tick();

    // Master 3 targets slave 1, master 0 targets slave 2
    m_req = 4'b1001; m_cmd = 4'b1001; m_tgt = tg(2, 0, 0, 1); s_ack = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      check("tgt_gnt_idx", 32'(gnt_idx), 0);
      check("tgt_gnt_valid", 32'(gnt_valid), 1);
      tick();
    end
    m_req = '0; s_ack = 1'b0;
    tick();

    // Read from master 2: ack at t, resp at t+3, stray ack in RESP
    m_req = 4'b0100; m_cmd = 4'b0000; m_tgt = tg(0, 0, 2, 0);
    tick();
    check("rd_gnt_idx", 32'(gnt_idx), 2);
    check("rd_s_req", 32'(s_req), 1);
    tick();
    s_ack = 1'b1; #1;
    check("rd_m_ack", 32'(m_ack), 4'b0100);
    check("rd_m_resp_t", 32'(m_resp), 0);
    tick();
    check("rd_resp_s_req", 32'(s_req), 0);
    check("rd_stray_ack", 32'(m_ack), 0);
    check("rd_m_resp_t1", 32'(m_resp), 0);
    tick();
    s_ack = 1'b0; #1;
    check("rd_m_resp_t2", 32'(m_resp), 0);
    tick();
    s_resp = 1'b1; m_req = '0; #1;
    check("rd_m_resp_t3", 32'(m_resp), 4'b0100);
    check("rd_m_ack_t3", 32'(m_ack), 0);
    tick();
    s_resp = 1'b0; #1;
    check("rd_done_valid", 32'(gnt_valid), 0);
    check("rd_done_resp", 32'(m_resp), 0);

    // Timeout: masters 1 and 3 write, slave never acks; last grant was 2
    m_req = 4'b1010; m_cmd = 4'b1010; m_tgt = tg(0, 2, 0, 2);
    tick();
    check("to_gnt_idx", 32'(gnt_idx), 3);
    for (int c = 0; c < 7; c++) begin
      tick();
      check("to_wait_valid", 32'(gnt_valid), 1);
      check("to_wait_pulse", 32'(timeout), 0);
    end
    tick();
    check("to_pulse", 32'(timeout), 1);
    check("to_valid_drop", 32'(gnt_valid), 0);
    tick();
    check("to_next_idx", 32'(gnt_idx), 1);
    check("to_next_valid", 32'(gnt_valid), 1);
    check("to_pulse_end", 32'(timeout), 0);

    // Protocol error: owning master 1 drops its request before ack
    m_req = 4'b0000; #1;
    check("pe_s_req", 32'(s_req), 0);
    tick();
    check("pe_pulse", 32'(proto_err), 1);
    check("pe_valid", 32'(gnt_valid), 0);
    tick();
    check("pe_pulse_end", 32'(proto_err), 0);

    // Reset in the middle of a read response phase
    m_req = 4'b0010; m_cmd = 4'b0000; m_tgt = tg(0, 2, 0, 0);
    tick();
    check("mr_gnt_idx", 32'(gnt_idx), 1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0; #1;
    check("mr_in_resp_s_req", 32'(s_req), 0);
    rst_n = 1'b0; s_resp = 1'b1;
    tick();
    check("mr_valid", 32'(gnt_valid), 0);
    check("mr_idx", 32'(gnt_idx), 0);
    check("mr_resp", 32'(m_resp), 0);
    check("mr_ack", 32'(m_ack), 0);
    check("mr_s_req", 32'(s_req), 0);
    rst_n = 1'b1; s_resp = 1'b0;
    m_req = 4'b1111; m_cmd = 4'b1111; m_tgt = tg(2, 2, 2, 2);
    tick();
    check("mr_prio_idx", 32'(gnt_idx), 0);
    check("mr_prio_valid", 32'(gnt_valid), 1);
    m_req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
